// File: rtl/ball_move_pkg.sv
// Shared pong definitions: ball FSM encoding, score limit, direction codes
// and small arithmetic helpers used by the ball mover.
package ball_move_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        SCORE = 2'd2
    } ball_state_e;

    // A player who reaches this many points ends the game.
    localparam logic [3:0] SCORE_MAX = 4'd9;

    // Direction encodings: column grows to the right, row grows downward.
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_UP    = 1'b0;

    // Absolute row distance computed in signed 13 bits so that rows near 0
    // never wrap to a huge unsigned value.
    function automatic logic [12:0] row_dist(input logic [11:0] a, input logic [11:0] b);
        logic signed [12:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[12] ? 13'(-d) : 13'(d);
    endfunction

    // Score increment that sticks at the game-ending limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= SCORE_MAX) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/ball_move_tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every STEP_DIV clocks.
module tick_gen #(
    parameter int STEP_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == LAST);

    // Count up to STEP_DIV-1, then wrap to 0 on the tick cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/ball_move.sv
// Pong ball mover: serves from the centre, steps one pixel diagonally per
// tick, bounces off walls and paddles, and keeps the score.
module ball_move #(
    parameter int DISP_COLS     = 800,
    parameter int DISP_ROWS     = 600,
    parameter int PADDLE_HEIGHT = 44,
    parameter int PADDLE_WIDTH  = 12,
    parameter int BALL_SIZE     = 8,
    parameter int PADDLE_COL_L  = 20,
    parameter int PADDLE_COL_R  = 780,
    parameter int STEP_DIV      = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        serve,
    input  logic [11:0] left_paddle_row,
    input  logic [11:0] right_paddle_row,
    output logic [11:0] ball_row,
    output logic [11:0] ball_col,
    output logic        ball_active,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        game_over
);

    import ball_move_pkg::*;

    localparam int HALF_BALL = BALL_SIZE / 2;

    localparam logic [11:0] CENTRE_ROW = 12'(DISP_ROWS / 2);
    localparam logic [11:0] CENTRE_COL = 12'(DISP_COLS / 2);
    localparam logic [11:0] ROW_TOP    = 12'(HALF_BALL);
    localparam logic [11:0] ROW_BOT    = 12'(DISP_ROWS - 1 - HALF_BALL);
    localparam logic [11:0] COL_LEFT   = 12'(HALF_BALL);
    localparam logic [11:0] COL_RIGHT  = 12'(DISP_COLS - 1 - HALF_BALL);
    // Ball centre column at which its edge touches a paddle face.
    localparam logic [11:0] LPAD_HIT_COL = 12'(PADDLE_COL_L + PADDLE_WIDTH / 2 + HALF_BALL);
    localparam logic [11:0] RPAD_HIT_COL = 12'(PADDLE_COL_R - PADDLE_WIDTH / 2 - HALF_BALL);
    // Largest centre-to-centre row distance that still counts as a hit.
    localparam logic [12:0] PADDLE_REACH = 13'(PADDLE_HEIGHT / 2 + HALF_BALL);

    ball_state_e state_reg, state_next;
    logic [11:0] ball_row_reg, ball_row_next;
    logic [11:0] ball_col_reg, ball_col_next;
    logic        dir_x_reg, dir_x_next;
    logic        dir_y_reg, dir_y_next;
    logic        serve_dir_reg, serve_dir_next;
    logic [3:0]  score_left_reg, score_left_next;
    logic [3:0]  score_right_reg, score_right_next;
    logic        tick;
    logic        hit_left, hit_right;

    tick_gen #(
        .STEP_DIV(STEP_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign hit_left  = (dir_x_reg == DIR_LEFT) && (ball_col_reg == LPAD_HIT_COL) &&
                       (row_dist(ball_row_reg, left_paddle_row) <= PADDLE_REACH);
    assign hit_right = (dir_x_reg == DIR_RIGHT) && (ball_col_reg == RPAD_HIT_COL) &&
                       (row_dist(ball_row_reg, right_paddle_row) <= PADDLE_REACH);

    assign ball_row    = ball_row_reg;
    assign ball_col    = ball_col_reg;
    assign ball_active = (state_reg == MOVE);
    assign score_left  = score_left_reg;
    assign score_right = score_right_reg;
    assign game_over   = (score_left_reg == SCORE_MAX) || (score_right_reg == SCORE_MAX);

    // State and datapath registers; reset drops any ball in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            ball_row_reg    <= CENTRE_ROW;
            ball_col_reg    <= CENTRE_COL;
            dir_x_reg       <= DIR_RIGHT;
            dir_y_reg       <= DIR_DOWN;
            serve_dir_reg   <= DIR_RIGHT;
            score_left_reg  <= 4'd0;
            score_right_reg <= 4'd0;
        end else begin
            state_reg       <= state_next;
            ball_row_reg    <= ball_row_next;
            ball_col_reg    <= ball_col_next;
            dir_x_reg       <= dir_x_next;
            dir_y_reg       <= dir_y_next;
            serve_dir_reg   <= serve_dir_next;
            score_left_reg  <= score_left_next;
            score_right_reg <= score_right_next;
        end
    end

    // Next-state logic: serve, per-tick step with reflections, scoring.
    always_comb begin
        state_next       = state_reg;
        ball_row_next    = ball_row_reg;
        ball_col_next    = ball_col_reg;
        dir_x_next       = dir_x_reg;
        dir_y_next       = dir_y_reg;
        serve_dir_next   = serve_dir_reg;
        score_left_next  = score_left_reg;
        score_right_next = score_right_reg;

        case (state_reg)
            IDLE: begin
                ball_row_next = CENTRE_ROW;
                ball_col_next = CENTRE_COL;
                if (serve && !game_over) begin
                    state_next     = MOVE;
                    dir_x_next     = serve_dir_reg;
                    dir_y_next     = DIR_DOWN;
                    serve_dir_next = ~serve_dir_reg;
                end
            end

            MOVE: begin
                if (tick) begin
                    if ((dir_x_reg == DIR_LEFT) && (ball_col_reg <= COL_LEFT)) begin
                        score_right_next = sat_inc(score_right_reg);
                        state_next       = SCORE;
                    end else if ((dir_x_reg == DIR_RIGHT) && (ball_col_reg >= COL_RIGHT)) begin
                        score_left_next = sat_inc(score_left_reg);
                        state_next      = SCORE;
                    end else begin
                        // Wall and paddle reflections are independent, so a
                        // corner hit flips both before this tick's step.
                        if ((dir_y_reg == DIR_UP) && (ball_row_reg <= ROW_TOP)) begin
                            dir_y_next = DIR_DOWN;
                        end else if ((dir_y_reg == DIR_DOWN) && (ball_row_reg >= ROW_BOT)) begin
                            dir_y_next = DIR_UP;
                        end
                        if (hit_left) begin
                            dir_x_next = DIR_RIGHT;
                        end else if (hit_right) begin
                            dir_x_next = DIR_LEFT;
                        end
                        ball_row_next = (dir_y_next == DIR_DOWN) ? ball_row_reg + 12'd1
                                                                 : ball_row_reg - 12'd1;
                        ball_col_next = (dir_x_next == DIR_RIGHT) ? ball_col_reg + 12'd1
                                                                  : ball_col_reg - 12'd1;
                    end
                end
            end

            SCORE: begin
                ball_row_next = CENTRE_ROW;
                ball_col_next = CENTRE_COL;
                state_next    = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ball_move.sv
// Directed bench for ball_move with a fast prescaler (STEP_DIV=4).
// Edge numbers in the table count rising edges after the last reset edge;
// the prescaler therefore ticks on every edge that is a multiple of 4.
module tb_ball_move;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        serve;
    logic [11:0] left_paddle_row;
    logic [11:0] right_paddle_row;
    logic [11:0] ball_row;
    logic [11:0] ball_col;
    logic        ball_active;
    logic [3:0]  score_left;
    logic [3:0]  score_right;
    logic        game_over;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    typedef struct {
        int          at_edge;
        logic        serve_after;
        logic [11:0] lrow_after;
        logic [11:0] row;
        logic [11:0] col;
        logic        active;
        logic [3:0]  sl;
        logic [3:0]  sr;
        logic        go;
        string       name;
    } vec_t;

    vec_t vecs[$];

    ball_move #(
        .DISP_COLS    (800),
        .DISP_ROWS    (600),
        .PADDLE_HEIGHT(44),
        .PADDLE_WIDTH (12),
        .BALL_SIZE    (8),
        .PADDLE_COL_L (20),
        .PADDLE_COL_R (780),
        .STEP_DIV     (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .serve           (serve),
        .left_paddle_row (left_paddle_row),
        .right_paddle_row(right_paddle_row),
        .ball_row        (ball_row),
        .ball_col        (ball_col),
        .ball_active     (ball_active),
        .score_left      (score_left),
        .score_right     (score_right),
        .game_over       (game_over)
    );

    always #5 clk = ~clk;

    // Right paddle follows the ball so every rightward rally is returned.
    initial begin
        right_paddle_row = 12'd300;
        forever begin
            @(negedge clk);
            right_paddle_row = ball_row;
        end
    end

    // Watchdog in case the design never leaves a state.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    function automatic vec_t mk(input int at_edge, input logic serve_after,
                                input logic [11:0] lrow_after, input logic [11:0] row,
                                input logic [11:0] col, input logic active,
                                input logic [3:0] sl, input logic [3:0] sr,
                                input logic go, input string name);
        vec_t v;
        v.at_edge = at_edge; v.serve_after = serve_after; v.lrow_after = lrow_after;
        v.row = row; v.col = col; v.active = active;
        v.sl = sl; v.sr = sr; v.go = go; v.name = name;
        return v;
    endfunction

    task automatic check_pos(input string name, input logic [11:0] row, input logic [11:0] col);
        check({name, "_row"}, 16'(ball_row), 16'(row));
        check({name, "_col"}, 16'(ball_col), 16'(col));
    endtask

    initial begin
        int n;
        rst_n           = 1'b0;
        serve           = 1'b0;
        left_paddle_row = 12'd238;

        // Reset: hold for three edges, the last one is edge 0.
        repeat (3) @(posedge clk);
        #1;
        edge_n = 0;
        check_pos("reset", 12'd300, 12'd400);
        check("reset_active", 16'(ball_active), 16'd0);
        check("reset_sl", 16'(score_left), 16'd0);
        check("reset_sr", 16'(score_right), 16'd0);
        check("reset_go", 16'(game_over), 16'd0);
        $display("reset: row=%0d col=%0d active=%0d", ball_row, ball_col, ball_active);

        // First rally: rightward serve, bottom wall, right paddle, top wall,
        // left paddle hit (distance 10), then a left miss with paddle at 100.
        vecs.push_back(mk(1,     1'b1, 12'd238, 12'd300, 12'd400, 1'b1, 4'd0, 4'd0, 1'b0, "serve"));
        vecs.push_back(mk(15,    1'b0, 12'd238, 12'd303, 12'd403, 1'b1, 4'd0, 4'd0, 1'b0, "tick3"));
        vecs.push_back(mk(16,    1'b0, 12'd238, 12'd304, 12'd404, 1'b1, 4'd0, 4'd0, 1'b0, "tick4"));
        vecs.push_back(mk(1180,  1'b0, 12'd238, 12'd595, 12'd695, 1'b1, 4'd0, 4'd0, 1'b0, "wall_reach"));
        vecs.push_back(mk(1184,  1'b0, 12'd238, 12'd594, 12'd696, 1'b1, 4'd0, 4'd0, 1'b0, "wall_bounce"));
        vecs.push_back(mk(1188,  1'b0, 12'd238, 12'd593, 12'd697, 1'b1, 4'd0, 4'd0, 1'b0, "wall_up"));
        vecs.push_back(mk(1484,  1'b0, 12'd238, 12'd519, 12'd769, 1'b1, 4'd0, 4'd0, 1'b0, "rpad_hit"));
        vecs.push_back(mk(3548,  1'b0, 12'd238, 12'd5,   12'd253, 1'b1, 4'd0, 4'd0, 1'b0, "top_bounce"));
        vecs.push_back(mk(4440,  1'b0, 12'd238, 12'd228, 12'd30,  1'b1, 4'd0, 4'd0, 1'b0, "lpad_reach"));
        vecs.push_back(mk(4444,  1'b0, 12'd100, 12'd229, 12'd31,  1'b1, 4'd0, 4'd0, 1'b0, "lpad_hit"));
        vecs.push_back(mk(10360, 1'b0, 12'd100, 12'd526, 12'd30,  1'b1, 4'd0, 4'd0, 1'b0, "lpad_pass"));
        vecs.push_back(mk(10364, 1'b0, 12'd100, 12'd527, 12'd29,  1'b1, 4'd0, 4'd0, 1'b0, "lpad_miss"));
        vecs.push_back(mk(10464, 1'b0, 12'd100, 12'd552, 12'd4,   1'b1, 4'd0, 4'd0, 1'b0, "edge_reach"));
        vecs.push_back(mk(10468, 1'b0, 12'd100, 12'd552, 12'd4,   1'b0, 4'd0, 4'd1, 1'b0, "score"));
        vecs.push_back(mk(10469, 1'b0, 12'd100, 12'd300, 12'd400, 1'b0, 4'd0, 4'd1, 1'b0, "recentre"));

        rst_n = 1'b1;
        serve = 1'b1;
        foreach (vecs[i]) begin
            while (edge_n < vecs[i].at_edge) step();
            check_pos(vecs[i].name, vecs[i].row, vecs[i].col);
            check({vecs[i].name, "_active"}, 16'(ball_active), 16'(vecs[i].active));
            check({vecs[i].name, "_sl"}, 16'(score_left), 16'(vecs[i].sl));
            check({vecs[i].name, "_sr"}, 16'(score_right), 16'(vecs[i].sr));
            check({vecs[i].name, "_go"}, 16'(game_over), 16'(vecs[i].go));
            $display("vec %s edge=%0d row=%0d col=%0d active=%0d sl=%0d sr=%0d",
                     vecs[i].name, edge_n, ball_row, ball_col, ball_active, score_left, score_right);
            serve           = vecs[i].serve_after;
            left_paddle_row = vecs[i].lrow_after;
        end

        // Saturation: left paddle out of reach, every rally ends on the left.
        left_paddle_row = 12'd4000;
        for (int k = 2; k <= 9; k++) begin
            serve = 1'b1;
            step();
            serve = 1'b0;
            check("rally_serve", 16'(ball_active), 16'd1);
            n = 0;
            while (ball_active && n < 8000) begin
                step();
                n++;
            end
            check("rally_bounded", 16'(n < 8000), 16'd1);
            check("rally_sr", 16'(score_right), 16'(k));
            check("rally_sl", 16'(score_left), 16'd0);
            check("rally_go", 16'(game_over), 16'(k == 9));
            step();
            check_pos("rally_centre", 12'd300, 12'd400);
            $display("rally %0d: cycles=%0d sl=%0d sr=%0d game_over=%0d",
                     k, n, score_left, score_right, game_over);
        end

        // Game over: serve must be ignored and the score must not exceed 9.
        serve = 1'b1;
        repeat (8) step();
        check("over_active", 16'(ball_active), 16'd0);
        check("over_sr", 16'(score_right), 16'd9);
        check("over_go", 16'(game_over), 16'd1);
        check_pos("over", 12'd300, 12'd400);
        $display("game over hold: active=%0d sr=%0d", ball_active, score_right);
        serve = 1'b0;

        // Reset clears the game; the next serve goes rightward again.
        rst_n = 1'b0;
        step();
        edge_n = 0;
        check("rst2_sr", 16'(score_right), 16'd0);
        check("rst2_go", 16'(game_over), 16'd0);
        rst_n = 1'b1;
        serve = 1'b1;
        step();
        serve = 1'b0;
        while (edge_n < 16) step();
        check_pos("rst2_tick4", 12'd304, 12'd404);
        while (edge_n < 40) step();
        check_pos("midflight", 12'd310, 12'd410);
        check("midflight_active", 16'(ball_active), 16'd1);
        $display("mid-flight: row=%0d col=%0d", ball_row, ball_col);

        // Reset while the ball is moving aborts the rally without scoring.
        rst_n = 1'b0;
        step();
        check_pos("abort", 12'd300, 12'd400);
        check("abort_active", 16'(ball_active), 16'd0);
        check("abort_sl", 16'(score_left), 16'd0);
        check("abort_sr", 16'(score_right), 16'd0);
        rst_n = 1'b1;
        step();
        check("abort_idle", 16'(ball_active), 16'd0);
        $display("abort: row=%0d col=%0d active=%0d", ball_row, ball_col, ball_active);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
